timer_slave: RTL

- Memory-mapped 8-bit down-counting timer. Sits on the data-memory slave side of the MiniRISC system bus, and is addressed by the CPU master port through the arbiter.
- Provides a programmable prescaler, one-shot and periodic modes, and a timeout flag.
- Drives an active-high, level-sensitive interrupt request into the CPU irq input.
- Read data is zero when the block is not selected, so it can be OR-combined with the other slaves.

---
 rtl/timer_slave.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/timer_slave.sv
// ---------------------------------------------------------------------------
// timer_slave
//
// Memory-mapped 8-bit down-counting timer for the MiniRISC data-memory slave
// side. It exposes a two-register window at BASEADDR and has a programmable
// prescaler, one-shot and periodic modes, a sticky timeout flag and a
// level-sensitive interrupt request.
//
// Register window (addr[0] selects the register):
//   +0 write : TR, the reload value. Also loads TM and restarts the prescaler.
//   +0 read  : TM, the current count.
//   +1 write : TC, control: [0] EN, [1] REP, [2] IE, [6:4] PS.
//   +1 read  : TS, status: {TOUT, PS[2:0], 1'b0, IE, REP, EN}.
//              A TS read clears TOUT.
//
// Ports:
//   clk            : system clock, rising-edge active
//   rst            : asynchronous reset, active low
//   s_mst2slv_addr : bus address
//   s_mst2slv_wr   : write strobe, one cycle per access
//   s_mst2slv_rd   : read strobe, one cycle per access
//   s_mst2slv_data : write data
//   s_slv2mst_data : read data, zero unless this block is selected and read,
//                    so it can be OR-combined with other slaves
//   irq            : interrupt request, IE & TOUT, active-high level
// ---------------------------------------------------------------------------
module timer_slave #(
  parameter logic [7:0] BASEADDR = 8'hC0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_mst2slv_addr,
  input  logic       s_mst2slv_wr,
  input  logic       s_mst2slv_rd,
  input  logic [7:0] s_mst2slv_data,
  output logic [7:0] s_slv2mst_data,
  output logic       irq
);

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic sel;
  logic tr_wr;
  logic tc_wr;
  logic ts_rd;

  assign sel   = (s_mst2slv_addr[7:1] == BASEADDR[7:1]);
  assign tr_wr = sel & s_mst2slv_wr & ~s_mst2slv_addr[0];
  assign tc_wr = sel & s_mst2slv_wr &  s_mst2slv_addr[0];
  assign ts_rd = sel & s_mst2slv_rd &  s_mst2slv_addr[0];

  // -------------------------------------------------------------------------
  // Register state
  // -------------------------------------------------------------------------
  logic [7:0]  tr_reg,    tr_next;
  logic [7:0]  tm_reg,    tm_next;
  logic        en_reg,    en_next;
  logic        rep_reg,   rep_next;
  logic        ie_reg,    ie_next;
  logic [2:0]  ps_reg,    ps_next;
  logic        tout_reg,  tout_next;
  logic [15:0] presc_reg, presc_next;

  // -------------------------------------------------------------------------
  // Prescaler tick generation
  //
  // The divide ratio is 1 for PS = 0 and 2^(2*PS+2) otherwise, so the number
  // of low prescaler bits that must all be ones before a tick is 0, 4, 6, ...
  // 16. Because the counter wraps to zero on every tick and is cleared on
  // any TC write (the only way PS can change), the bits above the mask are
  // always zero and a plain masked compare is sufficient.
  // -------------------------------------------------------------------------
  logic [4:0]  mask_width;
  logic [15:0] presc_mask;
  logic        tick;
  logic        tick_eff;
  logic        expire;

  always_comb begin
    if (ps_reg == 3'd0) begin
      mask_width = 5'd0;
    end else begin
      mask_width = {1'b0, ps_reg, 1'b0} + 5'd2;
    end
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_mask
      assign presc_mask[gi] = (mask_width > 5'(gi));
    end
  endgenerate

  assign tick = en_reg & ((presc_reg & presc_mask) == presc_mask);

  // A TC write that turns the timer off swallows a coincident tick; a TC
  // write that keeps EN set lets the tick act on TM and TOUT as usual.
  assign tick_eff = tick & ~(tc_wr & ~s_mst2slv_data[0]);

  // Expiry: a tick arriving while the count is already at zero.
  assign expire = tick_eff & (tm_reg == 8'd0);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // Prescaler: runs only while enabled, restarts on any register write
    // and wraps to zero on each tick.
    if (!en_reg || tr_wr || tc_wr || tick) begin
      presc_next = 16'd0;
    end else begin
      presc_next = presc_reg + 16'd1;
    end
  end

  always_comb begin
    tr_next = tr_reg;
    tm_next = tm_reg;

    if (tr_wr) begin
      // A reload write has priority over the count step; TOUT is still
      // handled independently below.
      tr_next = s_mst2slv_data;
      tm_next = s_mst2slv_data;
    end else if (tick_eff) begin
      if (tm_reg != 8'd0) begin
        tm_next = tm_reg - 8'd1;
      end else if (rep_reg) begin
        tm_next = tr_reg;
      end else begin
        tm_next = 8'd0;
      end
    end
  end

  always_comb begin
    en_next  = en_reg;
    rep_next = rep_reg;
    ie_next  = ie_reg;
    ps_next  = ps_reg;

    if (tc_wr) begin
      // The written control value wins over a one-shot expiry that would
      // otherwise clear EN in the same cycle.
      en_next  = s_mst2slv_data[0];
      rep_next = s_mst2slv_data[1];
      ie_next  = s_mst2slv_data[2];
      ps_next  = s_mst2slv_data[6:4];
    end else if (expire && !rep_reg) begin
      en_next  = 1'b0;
    end
  end

  always_comb begin
    // Setting TOUT beats clearing it, so an expiry coinciding with a TS read
    // is never lost.
    if (expire) begin
      tout_next = 1'b1;
    end else if (ts_rd) begin
      tout_next = 1'b0;
    end else begin
      tout_next = tout_reg;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tr_reg    <= 8'd0;
      tm_reg    <= 8'd0;
      en_reg    <= 1'b0;
      rep_reg   <= 1'b0;
      ie_reg    <= 1'b0;
      ps_reg    <= 3'd0;
      tout_reg  <= 1'b0;
      presc_reg <= 16'd0;
    end else begin
      tr_reg    <= tr_next;
      tm_reg    <= tm_next;
      en_reg    <= en_next;
      rep_reg   <= rep_next;
      ie_reg    <= ie_next;
      ps_reg    <= ps_next;
      tout_reg  <= tout_next;
      presc_reg <= presc_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic [7:0] ts_value;

  assign ts_value = {tout_reg, ps_reg, 1'b0, ie_reg, rep_reg, en_reg};

  always_comb begin
    s_slv2mst_data = 8'd0;
    if (sel && s_mst2slv_rd) begin
      if (s_mst2slv_addr[0]) begin
        s_slv2mst_data = ts_value;
      end else begin
        s_slv2mst_data = tm_reg;
      end
    end
  end

  assign irq = ie_reg & tout_reg;

endmodule
